// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder buffer turning bit-reversed 4-lane FFT output into natural bin order
module fft_out_reorder #(
    parameter int NBITS_out = 15,
    parameter int N         = 128,
    parameter int LOG2N     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic [2*NBITS_out-1:0] fftIn0_up,
    input  logic [2*NBITS_out-1:0] fftIn0_down,
    input  logic [2*NBITS_out-1:0] fftIn1_up,
    input  logic [2*NBITS_out-1:0] fftIn1_down,
    output logic [2*NBITS_out-1:0] fftOut0,
    output logic [2*NBITS_out-1:0] fftOut1,
    output logic [2*NBITS_out-1:0] fftOut2,
    output logic [2*NBITS_out-1:0] fftOut3,
    output logic                   o_valid,
    output logic                   o_sof,
    output logic                   o_overrun
);

    localparam int DW = 2 * NBITS_out;
    // Beat counters index N/4 beats of 4 lanes each.
    localparam int CW = LOG2N - 2;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N / 4 - 1);

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_state_t;

    // Reverse the bit order of a point index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [DW-1:0]  lane [4];
    logic [DW-1:0]  mem_q [2][N];

    logic [CW-1:0]  wc_q, wc_d;
    logic           wbank_q, wbank_d;
    rd_state_t      rd_state_q, rd_state_d;
    logic [CW-1:0]  rc_q, rc_d;
    logic           rbank_q, rbank_d;
    logic           overrun_q, overrun_d;

    logic [DW-1:0]  out_q [4];
    logic           valid_q;
    logic           sof_q;

    logic           swap;
    logic           rd_fire;

    // Gather the four input lanes in lane order for indexed writes.
    always_comb begin
        lane[0] = fftIn0_up;
        lane[1] = fftIn0_down;
        lane[2] = fftIn1_up;
        lane[3] = fftIn1_down;
    end

    assign swap    = i_enable && (wc_q == LAST_BEAT);
    assign rd_fire = (rd_state_q == RD_DRAIN);

    // Scatter each accepted beat into the write bank at bit-reversed addresses; banks are never reset.
    always_ff @(posedge clk) begin
        if (i_enable) begin
            for (int l = 0; l < 4; l++) begin
                mem_q[wbank_q][bitrev({wc_q, 2'(l)})] <= lane[l];
            end
        end
    end

    // Next-state for write counter, bank select, read FSM and sticky overrun.
    always_comb begin
        wc_d       = wc_q;
        wbank_d    = wbank_q;
        rd_state_d = rd_state_q;
        rc_d       = rc_q;
        rbank_d    = rbank_q;
        overrun_d  = overrun_q;

        if (i_enable) begin
            wc_d = wc_q + 1'b1;
        end

        if (rd_state_q == RD_DRAIN) begin
            if (rc_q == LAST_BEAT) begin
                rd_state_d = RD_IDLE;
            end else begin
                rc_d = rc_q + 1'b1;
            end
        end

        // A completed frame swaps banks and (re)starts the drain; a swap mid-drain is flagged but still taken.
        if (swap) begin
            wbank_d    = ~wbank_q;
            rbank_d    = wbank_q;
            rc_d       = '0;
            rd_state_d = RD_DRAIN;
            if ((rd_state_q == RD_DRAIN) && (rc_q != LAST_BEAT)) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_q       <= '0;
            wbank_q    <= 1'b0;
            rd_state_q <= RD_IDLE;
            rc_q       <= '0;
            rbank_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wc_q       <= wc_d;
            wbank_q    <= wbank_d;
            rd_state_q <= rd_state_d;
            rc_q       <= rc_d;
            rbank_q    <= rbank_d;
            overrun_q  <= overrun_d;
        end
    end

    // Register four consecutive natural-order bins per drain beat; data holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                out_q[j] <= '0;
            end
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            valid_q <= rd_fire;
            sof_q   <= rd_fire && (rc_q == '0);
            if (rd_fire) begin
                for (int j = 0; j < 4; j++) begin
                    out_q[j] <= mem_q[rbank_q][{rc_q, 2'(j)}];
                end
            end
        end
    end

    assign fftOut0   = out_q[0];
    assign fftOut1   = out_q[1];
    assign fftOut2   = out_q[2];
    assign fftOut3   = out_q[3];
    assign o_valid   = valid_q;
    assign o_sof     = sof_q;
    assign o_overrun = overrun_q;

endmodule
